// File: rtl/fetch_decode.sv
// Fetch/decode sequencer: owns the PC, reads a one-cycle-latency ROM, resolves JMP locally and
// issues decoded words over valid/ready. Optional illegal-opcode trap: FETCH_TRAP_ILLEGAL_EN.
module fetch_decode #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] addr_p,
  input  logic [DATA_W-1:0] prom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        opcode,
  output logic [3:0]        reg_sel,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [3:0] OP_JMP = 4'hC;

`ifdef FETCH_TRAP_ILLEGAL_EN
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, HALT} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE} state_t;
`endif

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   pc_next;
  logic [DATA_W-1:0]   ir;
  logic                ir_load;
  logic [3:0]          word_op;

  // Handshake: an instruction retires on a rising edge where instr_valid and instr_ready are
  // both high; instr_valid is only ever asserted in ISSUE and the decoded fields hold until then.
  assign word_op     = prom_data[15:12];
  assign addr_p      = pc;
  assign instr_valid = (state == ISSUE);
  assign opcode      = ir[15:12];
  assign reg_sel     = ir[11:8];
  assign imm         = ir[7:0];

`ifdef FETCH_TRAP_ILLEGAL_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        state_next = LATCH;
      end
      LATCH: begin
        ir_load = 1'b1;
        if (word_op == OP_JMP) begin
          pc_next    = ADDR_W'(prom_data[7:0]);
          state_next = run ? FETCH : IDLE;
        end
`ifdef FETCH_TRAP_ILLEGAL_EN
        // Trapped words leave pc on the faulting address.
        else if (word_op >= 4'hD) begin
          state_next = HALT;
        end
`endif
        else begin
          pc_next    = pc + ADDR_W'(1);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) state_next = run ? FETCH : IDLE;
      end
`ifdef FETCH_TRAP_ILLEGAL_EN
      HALT: begin
        state_next = HALT;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= ADDR_W'(RESET_PC);
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) ir <= prom_data;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: behavioural ROM, table-driven program, scoreboard of issued words
// packed as {opcode, reg_sel, imm, pc after the issue}.
module tb_fetch_decode;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] prom_data;
  logic [AW-1:0] addr_p;
  logic          instr_valid;
  logic [3:0]    opcode;
  logic [3:0]    reg_sel;
  logic [7:0]    imm;
  logic [AW-1:0] pc;
  logic          halted;

  fetch_decode #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .addr_p(addr_p), .prom_data(prom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .reg_sel(reg_sel), .imm(imm), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // ROM with a registered address: data for addr_p appears one cycle later.
  logic [15:0] rom [256];
  always @(posedge clk) prom_data <= rom[addr_p];

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
    logic [23:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Scoreboard: every handshake pops one expected word.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      issue_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %0h expected none", {opcode, reg_sel, imm, pc});
      end else begin
        check("issue_word", {8'h0, opcode, reg_sel, imm, pc}, {8'h0, exp_q.pop_front()});
      end
      check("addr_p_eq_pc", {24'h0, addr_p}, {24'h0, pc});
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_pc", {24'h0, pc}, 32'h0);
    check("rst_fields", {16'h0, opcode, reg_sel, imm}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic wait_issues(input int n);
    int target;
    bit done;
    target = issue_cnt + n;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #1;
      if (issue_cnt >= target) done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout: got %0d issues expected %0d", issue_cnt, target);
    end
  endtask

  task automatic wait_valid();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk);
      #1;
      if (instr_valid) done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic end_scenario(input string nm);
    check(nm, exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  vec_t prog [5];
  logic [7:0] edges;
  logic [15:0] held;

  initial begin
    prog[0] = '{8'd0, 16'h8004, 24'h800401};
    prog[1] = '{8'd1, 16'h8105, 24'h810502};
    prog[2] = '{8'd2, 16'h1100, 24'h110003};
    prog[3] = '{8'd3, 16'hA000, 24'hA00004};
    prog[4] = '{8'd4, 16'hB500, 24'hB50005};

    // Straight-line program, full throughput, first valid latency.
    clear_rom();
    for (int i = 0; i < 5; i++) begin
      rom[prog[i].addr] = prog[i].word;
      exp_q.push_back(prog[i].exp);
    end
    run = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    edges = 0;
    for (int c = 0; c < 20 && !instr_valid; c++) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check("first_valid_edge", {24'h0, edges}, 32'd3);
    wait_issues(5);
    end_scenario("seq_drained");

    // JMP resolved locally.
    clear_rom();
    rom[0] = 16'h1000;
    rom[1] = 16'hC005;
    rom[5] = 16'h2300;
    exp_q.push_back(24'h100001);
    exp_q.push_back(24'h230006);
    do_reset();
    wait_issues(2);
    end_scenario("jmp_drained");

    // Backpressure for 4 cycles in ISSUE.
    clear_rom();
    rom[0] = 16'h3456;
    rom[1] = 16'h4567;
    instr_ready = 1'b0;
    do_reset();
    wait_valid();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_valid", {31'h0, instr_valid}, 32'h1);
      check("bp_fields", {16'h0, opcode, reg_sel, imm}, 32'h3456);
      check("bp_pc", {24'h0, pc}, 32'h1);
    end
    exp_q.push_back(24'h345601);
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    wait_issues(1);
    instr_ready = 1'b0;
    @(negedge clk);
    check("bp_valid_drop", {31'h0, instr_valid}, 32'h0);
    end_scenario("bp_drained");

    // PC wrap 255 -> 0.
    clear_rom();
    rom[0] = 16'h7001;
    rom[1] = 16'hC0FF;
    rom[255] = 16'h5A5A;
    exp_q.push_back(24'h700101);
    exp_q.push_back(24'h5A5A00);
    exp_q.push_back(24'h700101);
    instr_ready = 1'b1;
    do_reset();
    wait_issues(3);
    end_scenario("wrap_drained");

    // Asynchronous reset while holding in ISSUE.
    clear_rom();
    rom[0] = 16'h6123;
    instr_ready = 1'b0;
    do_reset();
    wait_valid();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'h0, instr_valid}, 32'h0);
    check("async_pc", {24'h0, pc}, 32'h0);
    check("async_fields", {16'h0, opcode, reg_sel, imm}, 32'h0);
    instr_ready = 1'b1;
    exp_q.push_back(24'h612301);
    do_reset();
    wait_issues(1);
    end_scenario("async_drained");

    // run dropped mid-instruction parks in IDLE, then resumes.
    clear_rom();
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;
    instr_ready = 1'b0;
    do_reset();
    wait_valid();
    exp_q.push_back(24'h111101);
    run = 1'b0;
    instr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("park_valid", {31'h0, instr_valid}, 32'h0);
    check("park_pc", {24'h0, pc}, 32'h1);
    exp_q.push_back(24'h222202);
    run = 1'b1;
    wait_issues(1);
    end_scenario("park_drained");

    // Opcodes 13..15: trapped or issued depending on build.
    clear_rom();
    rom[0] = 16'h8004;
    rom[1] = 16'h8105;
    rom[2] = 16'hD000;
    rom[3] = 16'hE111;
    exp_q.push_back(24'h800401);
    exp_q.push_back(24'h810502);
`ifdef FETCH_TRAP_ILLEGAL_EN
    do_reset();
    wait_issues(2);
    repeat (5) @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      run = c[0];
      @(negedge clk);
      check("trap_halted", {31'h0, halted}, 32'h1);
      check("trap_pc", {24'h0, pc}, 32'h2);
      check("trap_addr", {24'h0, addr_p}, 32'h2);
      check("trap_valid", {31'h0, instr_valid}, 32'h0);
    end
    run = 1'b1;
`else
    exp_q.push_back(24'hD00003);
    exp_q.push_back(24'hE11104);
    do_reset();
    wait_issues(4);
    held = {15'h0, halted};
    check("no_trap_halted", {16'h0, held}, 32'h0);
`endif
    end_scenario("illegal_drained");

    rst_n = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
